matrix_generator_lfsr: RTL and testbench

//  Runtime generator of the H3 hash matrices for all hash tables. Replaces the fixed constant

---
 rtl/matrix_generator_lfsr_if.sv | 24 ++
 rtl/matrix_generator_lfsr.sv | 100 ++++++++++
 tb/tb_matrix_generator_lfsr.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_generator_lfsr_if.sv
// Bus between the hash-table controller and the H3 matrix generator.
// The controller (master) requests a matrix set; the generator (slave) publishes it.
interface matrix_generator_lfsr_if #(
   parameter int LFSR_WIDTH   = 32,
   parameter int MATRIX_WIDTH = 120
);
   logic                    regen_i;
   logic                    seed_we_i;
   logic [LFSR_WIDTH-1:0]   seed_i;
   logic                    busy_o;
   logic                    valid_o;
   logic                    done_o;
   logic [MATRIX_WIDTH-1:0] matrixes_o;

   modport master (
      output regen_i, seed_we_i, seed_i,
      input  busy_o, valid_o, done_o, matrixes_o
   );

   modport slave (
      input  regen_i, seed_we_i, seed_i,
      output busy_o, valid_o, done_o, matrixes_o
   );
endinterface

// File: rtl/matrix_generator_lfsr.sv
// Runtime H3 matrix generator: a Galois LFSR fills a shadow bank one row per cycle,
// and the finished set is copied to the output in a single commit cycle.
module matrix_generator_lfsr #(
   parameter int                    NUMBER_OF_TABLES = 4,
   parameter int                    HASH_ADR_WIDTH   = 5,
   parameter int                    KEY_WIDTH        = 6,
   parameter int                    LFSR_WIDTH       = 32,
   parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS        = 32'h80200003,
   parameter logic [LFSR_WIDTH-1:0] SEED             = 32'h00000001,
   parameter bit                    AUTO_INIT        = 1'b1
) (
   input logic                     clk,
   input logic                     reset,
   matrix_generator_lfsr_if.slave  bus
);

   localparam int ROWS  = NUMBER_OF_TABLES * HASH_ADR_WIDTH;
   localparam int MW    = ROWS * KEY_WIDTH;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [LFSR_WIDTH-1:0] SEED_INIT = (SEED == '0) ? LFSR_WIDTH'(1) : SEED;
   localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, GEN, COMMIT} state_t;

   state_t                state;
   logic [LFSR_WIDTH-1:0] lfsr;
   logic [LFSR_WIDTH-1:0] lfsr_next;
   logic [KEY_WIDTH-1:0]  candidate;
   logic [ROW_W-1:0]      row_cnt;
   logic [MW-1:0]         shadow;
   logic [MW-1:0]         matrixes;
   logic                  busy;
   logic                  valid;
   logic                  done;

   // One full row of LFSR bits per cycle: KEY_WIDTH Galois steps unrolled.
   always_comb begin
      lfsr_next = lfsr;
      for (int n = 0; n < KEY_WIDTH; n++) begin
         lfsr_next = (lfsr_next >> 1) ^ (lfsr_next[0] ? LFSR_TAPS : '0);
      end
      candidate = lfsr_next[KEY_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         matrixes <= '0;
         shadow   <= '0;
         valid    <= 1'b0;
         done     <= 1'b0;
         row_cnt  <= '0;
         lfsr     <= SEED_INIT;
         state    <= AUTO_INIT ? GEN : IDLE;
         busy     <= AUTO_INIT;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.seed_we_i) begin
                  lfsr <= (bus.seed_i == '0) ? LFSR_WIDTH'(1) : bus.seed_i;
               end
               if (bus.regen_i) begin
                  state   <= GEN;
                  busy    <= 1'b1;
                  row_cnt <= '0;
               end
            end
            // All-zero rows would make a hash bit constant, so they are skipped.
            GEN: begin
               lfsr <= lfsr_next;
               if (candidate != '0) begin
                  shadow[int'(row_cnt)*KEY_WIDTH +: KEY_WIDTH] <= candidate;
                  if (row_cnt == LAST_ROW) begin
                     state <= COMMIT;
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end
            end
            COMMIT: begin
               matrixes <= shadow;
               valid    <= 1'b1;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o     = busy;
   assign bus.valid_o    = valid;
   assign bus.done_o     = done;
   assign bus.matrixes_o = matrixes;

endmodule

// File: tb/tb_matrix_generator_lfsr.sv
// Bench for matrix_generator_lfsr: default instance plus a KEY_WIDTH=2, AUTO_INIT=0 instance,
// with a queue-based scoreboard fed by a bit-serial LFSR reference model.
module tb_matrix_generator_lfsr;

   localparam int          R    = 20;
   localparam logic [31:0] TAPS = 32'h80200003;

   typedef struct {
      logic [119:0] m;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic reset1;
   logic reset2;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   exp_t         q1[$];
   exp_t         q2[$];
   logic [31:0]  ms1;
   logic [31:0]  ms2;
   logic [119:0] first_set;
   logic [119:0] old_set;
   logic [31:0]  first_rows[R];

   matrix_generator_lfsr_if #(.LFSR_WIDTH(32), .MATRIX_WIDTH(120)) bus1 ();
   matrix_generator_lfsr_if #(.LFSR_WIDTH(32), .MATRIX_WIDTH(40))  bus2 ();

   matrix_generator_lfsr dut1 (.clk(clk), .reset(reset1), .bus(bus1));

   matrix_generator_lfsr #(.KEY_WIDTH(2), .AUTO_INIT(1'b0)) dut2 (
      .clk(clk), .reset(reset2), .bus(bus2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [119:0] act, input logic [119:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: bit-serial LFSR stream cut into kw-bit rows, zero rows dropped.
   task automatic model_gen(input int kw, inout logic [31:0] s, output logic [119:0] m,
                            output int z, output logic [31:0] rows[R]);
      logic [31:0] row;
      int k = 0;
      int steps = 0;
      m = '0;
      z = 0;
      while (k < R && steps < 100000) begin
         for (int n = 0; n < kw; n++) s = (s >> 1) ^ (s[0] ? TAPS : 32'h0);
         steps++;
         row = s & ((32'h1 << kw) - 1);
         if (row == 0) z++;
         else begin
            rows[k] = row;
            m = m | (120'(row) << (k * kw));
            k++;
         end
      end
   endtask

   task automatic push_expected(input int which, input int base_due);
      exp_t        e;
      int          z;
      logic [31:0] rows[R];
      if (which == 1) model_gen(6, ms1, e.m, z, rows);
      else            model_gen(2, ms2, e.m, z, rows);
      e.due = base_due + z;
      if (which == 1) q1.push_back(e);
      else            q2.push_back(e);
   endtask

   // Drives one request for one cycle; only meant for a DUT that is idle.
   task automatic apply_stimulus(input int which, input logic regen, input logic we, input logic [31:0] seed);
      @(negedge clk);
      if (which == 1) begin
         bus1.regen_i = regen; bus1.seed_we_i = we; bus1.seed_i = seed;
         if (we) ms1 = (seed == 0) ? 32'h1 : seed;
      end else begin
         bus2.regen_i = regen; bus2.seed_we_i = we; bus2.seed_i = seed;
         if (we) ms2 = (seed == 0) ? 32'h1 : seed;
      end
      if (regen) push_expected(which, cyc + R + 2);
      @(negedge clk);
      if (which == 1) begin bus1.regen_i = 0; bus1.seed_we_i = 0; end
      else            begin bus2.regen_i = 0; bus2.seed_we_i = 0; end
   endtask

   task automatic wait_idle(input int which);
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (which == 1 && !bus1.busy_o && q1.size() == 0) return;
         if (which == 2 && !bus2.busy_o && q2.size() == 0) return;
      end
      check_output("wait_idle timeout", 120'(which), 120'(0));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus1.done_o) begin
         if (q1.size() == 0) check_output("dut1 unexpected done", 120'(bus1.done_o), 120'(0));
         else begin
            e = q1.pop_front();
            check_output("dut1 matrixes", bus1.matrixes_o, e.m);
            check_output("dut1 valid", 120'(bus1.valid_o), 120'(1));
            check_output("dut1 latency", 120'(cyc), 120'(e.due));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      int   zero_rows;
      if (bus2.done_o) begin
         if (q2.size() == 0) check_output("dut2 unexpected done", 120'(bus2.done_o), 120'(0));
         else begin
            e = q2.pop_front();
            zero_rows = 0;
            for (int k = 0; k < R; k++) if (bus2.matrixes_o[k*2 +: 2] == 2'b00) zero_rows++;
            check_output("dut2 matrixes", 120'(bus2.matrixes_o), e.m);
            check_output("dut2 zero rows", 120'(zero_rows), 120'(0));
            check_output("dut2 latency", 120'(cyc), 120'(e.due));
         end
      end
   end

   initial begin
      logic [119:0] m;
      int           z;
      logic [31:0]  s;
      reset1 = 1; reset2 = 1;
      bus1.regen_i = 0; bus1.seed_we_i = 0; bus1.seed_i = 0;
      bus2.regen_i = 0; bus2.seed_we_i = 0; bus2.seed_i = 0;
      repeat (2) @(negedge clk);
      check_output("reset matrixes", bus1.matrixes_o, '0);
      check_output("reset valid", 120'(bus1.valid_o), 120'(0));
      check_output("reset done", 120'(bus1.done_o), 120'(0));
      check_output("reset busy auto", 120'(bus1.busy_o), 120'(1));
      check_output("reset busy dut2", 120'(bus2.busy_o), 120'(0));
      check_output("reset valid dut2", 120'(bus2.valid_o), 120'(0));
      ms1 = 32'h1; ms2 = 32'h1;
      push_expected(1, cyc + R + 1);
      reset1 = 0; reset2 = 0;
      repeat (5) @(negedge clk);
      check_output("gen valid low", 120'(bus1.valid_o), 120'(0));
      check_output("gen busy high", 120'(bus1.busy_o), 120'(1));
      wait_idle(1);

      s = 32'h1;
      model_gen(6, s, m, z, first_rows);
      first_set = bus1.matrixes_o;
      check_output("layout t3r4", 120'(bus1.matrixes_o[119:114]), 120'(first_rows[19]));
      check_output("layout t0r0", 120'(bus1.matrixes_o[5:0]), 120'(first_rows[0]));
      for (int k = 0; k < R; k++)
         check_output("layout walk", 120'(bus1.matrixes_o[k*6 +: 6]), 120'(first_rows[k]));

      apply_stimulus(1, 0, 1, 32'h0);
      apply_stimulus(1, 1, 0, 32'h0);
      wait_idle(1);
      apply_stimulus(1, 1, 1, 32'hDEADBEEF);
      wait_idle(1);
      apply_stimulus(1, 1, 0, 32'h0);
      wait_idle(1);

      old_set = bus1.matrixes_o;
      apply_stimulus(1, 1, 0, 32'h0);
      repeat (4) @(negedge clk);
      bus1.regen_i = 1; bus1.seed_we_i = 1; bus1.seed_i = $urandom;
      check_output("hold valid", 120'(bus1.valid_o), 120'(1));
      check_output("hold matrixes", bus1.matrixes_o, old_set);
      @(negedge clk);
      bus1.regen_i = 0; bus1.seed_we_i = 0;
      repeat (5) @(negedge clk);
      check_output("hold matrixes late", bus1.matrixes_o, old_set);
      wait_idle(1);
      repeat (30) @(negedge clk);

      apply_stimulus(1, 1, 0, 32'h0);
      repeat (6) @(negedge clk);
      reset1 = 1;
      @(negedge clk);
      check_output("midrst matrixes", bus1.matrixes_o, '0);
      check_output("midrst valid", 120'(bus1.valid_o), 120'(0));
      check_output("midrst busy", 120'(bus1.busy_o), 120'(1));
      q1.delete();
      ms1 = 32'h1;
      push_expected(1, cyc + R + 1);
      reset1 = 0;
      wait_idle(1);
      check_output("midrst final set", bus1.matrixes_o, first_set);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(2, 1, (i != 3), $urandom);
         wait_idle(2);
      end

      repeat (5) @(negedge clk);
      check_output("dut1 queue empty", 120'(q1.size()), 120'(0));
      check_output("dut2 queue empty", 120'(q2.size()), 120'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
